bcd_serial_add_ctrl: RTL
========================

// Module: bcd_serial_add_ctrl
// PURPOSE
//  Sequencer that adds two DIGITS-wide packed-BCD operands using one shared
//  single-digit BCD adder, one digit per clock, least-significant digit first.
//  Sits between an operand producer and a result consumer. Both sides use a
//  valid/ready handshake. Replaces a wide combinational BCD adder where area matters.
// PARAMETERS
//  DIGITS  4  number of BCD digits per operand (>=1); operands are 4*DIGITS bits
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  in_valid   in   1         operands a, b and cin are valid
//  in_ready   out  1         controller can accept operands (IDLE only)
//  a          in   4*DIGITS  packed BCD operand A, digit 0 = a[3:0]
//  b          in   4*DIGITS  packed BCD operand B
//  cin        in   1         decimal carry-in
//  out_valid  out  1         sum, cout and err are valid
//  out_ready  in   1         consumer accepts the result
//  sum        out  4*DIGITS  packed BCD sum
//  cout       out  1         decimal carry-out of the most-significant digit
//  err        out  1         at least one input digit was >9 (non-BCD)
//  busy       out  1         high in ADD and DONE
// BEHAVIOUR
//  Reset: state=IDLE. in_ready=1. out_valid=0. busy=0. sum=0. cout=0. err=0.
//   Digit index=0. Reset takes effect immediately and aborts any operation in flight.
//  FSM states: IDLE, ADD, DONE.
//   IDLE: in_ready=1. On in_valid&in_ready, latch a, b and cin, clear err and the
//         digit index, then go to ADD.
//   ADD:  on each cycle, process digit i: s = a_i + b_i + c, as a 5-bit value.
//         If s>9: sum_i = (s+6)[3:0], c=1. Otherwise: sum_i = s[3:0], c=0.
//         err |= (a_i>9)|(b_i>9). For non-BCD inputs the same rule applies,
//         so the digit result is defined even though it is meaningless.
//         When i==DIGITS-1, cout=c and go to DONE. Otherwise i=i+1.
//   DONE: out_valid=1. sum, cout and err hold stable until out_ready.
//         On out_valid&out_ready, go to IDLE.
//  Latency: in the accept cycle the FSM is in IDLE. Digits are processed in the
//   next DIGITS cycles. out_valid rises on the cycle after the last digit.
//   Accept-to-out_valid = DIGITS+1 clocks. Best-case throughput is one result
//   per DIGITS+2 clocks.
//  in_ready is 0 in ADD and DONE. in_valid is ignored there, with no queuing.
//  out_valid is independent of out_ready; waiting on out_ready never drops or
//   changes a result.
//  sum/cout/err keep their last values in IDLE. They are only meaningful while
//   out_valid=1.
//  Width rule: the digit index is $clog2(DIGITS) bits wide, minimum 1 bit.
//   The digit index never wraps past DIGITS-1.
//  Edge cases:
//   - DIGITS=1: ADD lasts exactly one cycle.
//   - Max carry chain: 9..9 + 9..9 + cin=1 gives 9..9 with cout=1.
//   - out_ready held high in DONE: DONE lasts exactly one cycle.
// STRUCTURE
//  Shared package bcd_pkg holds:
//   - state enum: IDLE, ADD, DONE.
//   - localparam BCD_MAX=4'd9.
//   - localparam BCD_CORR=4'd6.
//  Sub-module bcd_digit_add is purely combinational:
//   a[3:0], b[3:0], ci -> s[3:0], co, bad.
//   Exactly one instance is used, shared across all digits via a mux on the digit index.
//  The controller holds the FSM, the digit index, the operand shift registers and
//   the sum shift register. Shifting is allowed in place of indexed muxing, provided
//   the cycle behaviour above is unchanged.
// TESTING (DIGITS=4)
//  1. a=1234, b=5678, cin=0
//     -> 5 clocks after accept: out_valid=1, sum=6912, cout=0, err=0.
//  2. a=9999, b=0001, cin=0 -> sum=0000, cout=1 (full carry ripple).
//     a=9999, b=9999, cin=1 -> sum=9999, cout=1.
//  3. a=0000, b=0000, cin=1 -> sum=0001, cout=0.
//     a=0005, b=0005, cin=0 -> sum=0010.
//  4. a=00A0, b=0001 -> err=1 and out_valid still asserted.
//     The next clean op, 0001+0001, gives err=0 and sum=0002.
//  5. Backpressure: hold out_ready=0 for 3 cycles in DONE
//     -> sum/cout/err stable, in_ready=0, in_valid pulses are ignored.
//     Release -> IDLE next cycle.
//  6. Assert rst_n=0 in the middle of ADD, at digit 2
//     -> outputs go to reset values immediately, with no out_valid.
//     After release, a new op 0010+0020 gives sum=0030.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// Holds the controller state encoding and the BCD digit limits.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder, purely combinational.
// Non-BCD digits still get a defined result and raise bad.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       bad
);

    logic [4:0] w_raw;

    // Binary sum, then +6 correction when the digit overflows past 9
    always_comb begin
        w_raw = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        co    = (w_raw > {1'b0, BCD_MAX});
        s     = co ? (w_raw[3:0] + BCD_CORR) : w_raw[3:0];
        bad   = (a > BCD_MAX) | (b > BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder with valid/ready on both sides.
// One shared digit adder, LSD first; operands and sum shift by a digit per clock.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err,
    output logic                busy
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_c;
    logic            r_cout;
    logic            r_err;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic [3:0]      w_s;
    logic            w_co;
    logic            w_bad;
    logic [W-1:0]    w_sum_nxt;

    bcd_digit_add u_digit (
        .a   (r_a[3:0]),
        .b   (r_b[3:0]),
        .ci  (r_c),
        .s   (w_s),
        .co  (w_co),
        .bad (w_bad)
    );

    if (DIGITS == 1) begin : g_one
        assign w_sum_nxt = w_s;
    end else begin : g_many
        assign w_sum_nxt = {w_s, r_sum[W-1:4]};
    end

    // Sequencer: accept operands, add one digit per clock, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_c         <= 1'b0;
            r_cout      <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_c        <= cin;
                        r_err      <= 1'b0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ADD;
                    end
                end
                ADD: begin
                    r_a   <= r_a >> 4;
                    r_b   <= r_b >> 4;
                    r_sum <= w_sum_nxt;
                    r_c   <= w_co;
                    r_err <= r_err | w_bad;
                    if (r_idx == LAST) begin
                        r_cout      <= w_co;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign err       = r_err;

endmodule
